hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch / memory-wait arbitration,
// operand forwarding select and saturating stall/flush event counters.
module hazard_ctrl #(
   parameter int unsigned RegAddrWidth = 5,
   parameter int unsigned CntWidth     = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [RegAddrWidth-1:0] id_rs1,
   input  logic [RegAddrWidth-1:0] id_rs2,
   input  logic                    id_rs1_used,
   input  logic                    id_rs2_used,
   input  logic [RegAddrWidth-1:0] ex_rs1,
   input  logic [RegAddrWidth-1:0] ex_rs2,
   input  logic [RegAddrWidth-1:0] ex_rd,
   input  logic                    ex_reg_en,
   input  logic                    ex_mem_read,
   input  logic [RegAddrWidth-1:0] mem_rd,
   input  logic                    mem_reg_en,
   input  logic [RegAddrWidth-1:0] wb_rd,
   input  logic                    wb_reg_en,
   input  logic                    mem_access,
   input  logic                    dmem_ready,
   input  logic                    branch_taken_ex,
   output logic                    pc_stall,
   output logic                    if_id_stall,
   output logic                    id_ex_stall,
   output logic                    ex_mem_stall,
   output logic                    if_id_flush,
   output logic                    id_ex_flush,
   output logic [1:0]              fwd_a_sel,
   output logic [1:0]              fwd_b_sel,
   output logic [1:0]              state,
   output logic [CntWidth-1:0]     stall_cycles,
   output logic [CntWidth-1:0]     flush_count
);

   typedef enum logic [1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      FLUSH      = 2'b10,
      MEM_WAIT   = 2'b11
   } state_t;

   state_t state_q, state_d;
   logic   mem_wait;
   logic   load_use;
   logic   rs1_hit;
   logic   rs2_hit;

   // EX/MEM result is newer than MEM/WB, so it wins when both match.
   function automatic logic [1:0] fwd_sel(
      input logic [RegAddrWidth-1:0] src,
      input logic [RegAddrWidth-1:0] m_rd,
      input logic                    m_en,
      input logic [RegAddrWidth-1:0] w_rd,
      input logic                    w_en
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (m_en && (m_rd != '0) && (m_rd == src))
         sel = 2'b01;
      else if (w_en && (w_rd != '0) && (w_rd == src))
         sel = 2'b10;
      return sel;
   endfunction

   always_comb begin
      mem_wait = mem_access & ~dmem_ready;
      rs1_hit  = id_rs1_used & (id_rs1 == ex_rd);
      rs2_hit  = id_rs2_used & (id_rs2 == ex_rd);
      load_use = ex_mem_read & ex_reg_en & (ex_rd != '0) & (rs1_hit | rs2_hit);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   // Outputs are held inactive for the whole time reset is low, not just
   // until the next edge.
   always_comb begin
      state_d      = RUN;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      fwd_a_sel    = 2'b00;
      fwd_b_sel    = 2'b00;
      if (reset) begin
         fwd_a_sel = fwd_sel(ex_rs1, mem_rd, mem_reg_en, wb_rd, wb_reg_en);
         fwd_b_sel = fwd_sel(ex_rs2, mem_rd, mem_reg_en, wb_rd, wb_reg_en);
         if (mem_wait) begin
            state_d      = MEM_WAIT;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
         end else if (branch_taken_ex) begin
            state_d     = FLUSH;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            state_d     = LOAD_STALL;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
         end
      end
   end

   assign state = state_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (pc_stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CntWidth'(1);
         if (if_id_flush && (flush_count != '1))
            flush_count <= flush_count + CntWidth'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural reference model.
module tb_hazard_ctrl;

   typedef struct {
      logic [4:0] id_rs1, id_rs2;
      logic       id_rs1_used, id_rs2_used;
      logic [4:0] ex_rs1, ex_rs2, ex_rd;
      logic       ex_reg_en, ex_mem_read;
      logic [4:0] mem_rd;
      logic       mem_reg_en;
      logic [4:0] wb_rd;
      logic       wb_reg_en;
      logic       mem_access, dmem_ready, branch_taken_ex;
   } in_t;

   // ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush}
   typedef struct {
      in_t        in;
      logic [5:0] ctl;
      logic [1:0] fa, fb;
      string      name;
   } vec_t;

   typedef struct {
      logic [5:0] ctl;
      logic [1:0] fa, fb;
      int         cond;
   } exp_t;

   logic       clock, reset;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_rs1_used, id_rs2_used, ex_reg_en, ex_mem_read;
   logic       mem_reg_en, wb_reg_en, mem_access, dmem_ready, branch_taken_ex;

   logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic        if_id_flush, id_ex_flush;
   logic [1:0]  fwd_a_sel, fwd_b_sel, state;
   logic [15:0] stall_cycles, flush_count;

   logic        s_pc_stall, s_if_id_stall, s_id_ex_stall, s_ex_mem_stall;
   logic        s_if_id_flush, s_id_ex_flush;
   logic [1:0]  s_fwd_a_sel, s_fwd_b_sel, s_state;
   logic [3:0]  s_stall_cycles, s_flush_count;

   int n_checks = 0;
   int n_fail   = 0;
   int e_state, e_stall, e_flush;
   vec_t vecs[12];

   hazard_ctrl #(.RegAddrWidth(5), .CntWidth(16)) dut (
      .clock(clock), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_reg_en(ex_reg_en), .ex_mem_read(ex_mem_read),
      .mem_rd(mem_rd), .mem_reg_en(mem_reg_en),
      .wb_rd(wb_rd), .wb_reg_en(wb_reg_en),
      .mem_access(mem_access), .dmem_ready(dmem_ready),
      .branch_taken_ex(branch_taken_ex),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall),
      .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state(state),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   hazard_ctrl #(.RegAddrWidth(5), .CntWidth(4)) dut_sat (
      .clock(clock), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_reg_en(ex_reg_en), .ex_mem_read(ex_mem_read),
      .mem_rd(mem_rd), .mem_reg_en(mem_reg_en),
      .wb_rd(wb_rd), .wb_reg_en(wb_reg_en),
      .mem_access(mem_access), .dmem_ready(dmem_ready),
      .branch_taken_ex(branch_taken_ex),
      .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall),
      .id_ex_stall(s_id_ex_stall), .ex_mem_stall(s_ex_mem_stall),
      .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
      .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel), .state(s_state),
      .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic in_t idle();
      in_t v;
      v = '{default: '0};
      v.dmem_ready = 1'b1;
      return v;
   endfunction

   function automatic int sat(input int n, input int max);
      return (n > max) ? max : n;
   endfunction

   function automatic logic [1:0] ref_fwd(input in_t v, input logic [4:0] src);
      if (src == 0) return 2'b00;
      if (v.mem_reg_en && v.mem_rd == src) return 2'b01;
      if (v.wb_reg_en && v.wb_rd == src) return 2'b10;
      return 2'b00;
   endfunction

   // Event classification from the hazard rules, highest priority first.
   function automatic exp_t model(input in_t v);
      exp_t e;
      bit   waiting, uses_load;
      waiting   = v.mem_access && !v.dmem_ready;
      uses_load = v.ex_mem_read && v.ex_reg_en && v.ex_rd != 0 &&
                  ((v.id_rs1_used && v.id_rs1 == v.ex_rd) ||
                   (v.id_rs2_used && v.id_rs2 == v.ex_rd));
      e.fa = ref_fwd(v, v.ex_rs1);
      e.fb = ref_fwd(v, v.ex_rs2);
      if (waiting) begin
         e.ctl = 6'b111100; e.cond = 3;
      end else if (v.branch_taken_ex) begin
         e.ctl = 6'b000011; e.cond = 2;
      end else if (uses_load) begin
         e.ctl = 6'b110001; e.cond = 1;
      end else begin
         e.ctl = 6'b000000; e.cond = 0;
      end
      return e;
   endfunction

   task automatic drive(input in_t v);
      id_rs1 = v.id_rs1; id_rs2 = v.id_rs2;
      id_rs1_used = v.id_rs1_used; id_rs2_used = v.id_rs2_used;
      ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
      ex_reg_en = v.ex_reg_en; ex_mem_read = v.ex_mem_read;
      mem_rd = v.mem_rd; mem_reg_en = v.mem_reg_en;
      wb_rd = v.wb_rd; wb_reg_en = v.wb_reg_en;
      mem_access = v.mem_access; dmem_ready = v.dmem_ready;
      branch_taken_ex = v.branch_taken_ex;
   endtask

   function automatic logic [5:0] ctl_now();
      return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush};
   endfunction

   task automatic comb_check(input in_t v);
      exp_t e;
      e = model(v);
      chk("ctl", 32'(ctl_now()), 32'(e.ctl));
      chk("fwd_a", 32'(fwd_a_sel), 32'(e.fa));
      chk("fwd_b", 32'(fwd_b_sel), 32'(e.fb));
   endtask

   task automatic clk_check(input in_t v);
      exp_t e;
      e = model(v);
      @(posedge clock);
      if (e.ctl[5]) e_stall++;
      if (e.ctl[1]) e_flush++;
      e_state = e.cond;
      #1;
      chk("state", 32'(state), 32'(e_state));
      chk("stall_cycles", 32'(stall_cycles), 32'(sat(e_stall, 65535)));
      chk("flush_count", 32'(flush_count), 32'(sat(e_flush, 65535)));
      chk("sat_stall", 32'(s_stall_cycles), 32'(sat(e_stall, 15)));
      chk("sat_flush", 32'(s_flush_count), 32'(sat(e_flush, 15)));
   endtask

   task automatic step(input in_t v);
      drive(v);
      #2;
      comb_check(v);
      clk_check(v);
   endtask

   // Entered and left 1 time unit after a rising edge; inputs stay as driven.
   task automatic do_reset();
      reset = 1'b0;
      #2;
      chk("rst_ctl", 32'(ctl_now()), 32'd0);
      chk("rst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_cnt", 32'({stall_cycles, flush_count}), 32'd0);
      @(posedge clock);
      #1;
      chk("rst_hold_state", 32'(state), 32'd0);
      chk("rst_hold_cnt", 32'({stall_cycles, flush_count, s_stall_cycles}), 32'd0);
      reset = 1'b1;
      e_state = 0; e_stall = 0; e_flush = 0;
   endtask

   initial begin
      in_t v, wt, lu, all3;

      for (int i = 0; i < 12; i++) begin
         vecs[i].in = idle(); vecs[i].ctl = '0; vecs[i].fa = '0; vecs[i].fb = '0;
      end
      lu = idle();
      lu.ex_mem_read = 1; lu.ex_reg_en = 1; lu.ex_rd = 5; lu.id_rs1 = 5; lu.id_rs1_used = 1;
      vecs[0].name = "idle";
      vecs[1].name = "lu_rs1";   vecs[1].in = lu; vecs[1].ctl = 6'b110001;
      vecs[2].name = "lu_unused"; vecs[2].in = lu;
      vecs[2].in.id_rs1_used = 0; vecs[2].in.id_rs2 = 5;
      vecs[3].name = "lu_r0";    vecs[3].in = lu; vecs[3].in.ex_rd = 0; vecs[3].in.id_rs1 = 0;
      vecs[4].name = "lu_noen";  vecs[4].in = lu; vecs[4].in.ex_reg_en = 0;
      vecs[5].name = "br_lu";    vecs[5].in = lu; vecs[5].in.branch_taken_ex = 1;
      vecs[5].ctl = 6'b000011;
      vecs[6].name = "wait_br";  vecs[6].in = lu; vecs[6].in.branch_taken_ex = 1;
      vecs[6].in.mem_access = 1; vecs[6].in.dmem_ready = 0; vecs[6].ctl = 6'b111100;
      vecs[7].name = "lu_rs2";   vecs[7].in = lu; vecs[7].in.id_rs1_used = 0;
      vecs[7].in.id_rs2 = 5; vecs[7].in.id_rs2_used = 1; vecs[7].in.mem_access = 1;
      vecs[7].ctl = 6'b110001;
      v = idle();
      v.mem_rd = 7; v.wb_rd = 7; v.mem_reg_en = 1; v.wb_reg_en = 1; v.ex_rs1 = 7; v.ex_rs2 = 7;
      vecs[8].name = "fwd_mem";  vecs[8].in = v; vecs[8].fa = 2'b01; vecs[8].fb = 2'b01;
      vecs[9].name = "fwd_wb";   vecs[9].in = v; vecs[9].in.mem_reg_en = 0;
      vecs[9].fa = 2'b10; vecs[9].fb = 2'b10;
      vecs[10].name = "fwd_r0";  vecs[10].in = v; vecs[10].in.mem_rd = 0; vecs[10].in.wb_rd = 0;
      vecs[10].in.ex_rs1 = 0; vecs[10].in.ex_rs2 = 0;
      vecs[11].name = "fwd_mix"; vecs[11].in = v; vecs[11].in.mem_rd = 3; vecs[11].in.ex_rs1 = 3;
      vecs[11].in.wb_rd = 9; vecs[11].in.ex_rs2 = 9; vecs[11].fa = 2'b01; vecs[11].fb = 2'b10;

      wt = idle(); wt.mem_access = 1; wt.dmem_ready = 0;
      wt.mem_rd = 4; wt.mem_reg_en = 1; wt.ex_rs1 = 4;

      reset = 1'b0;
      drive(wt);
      @(posedge clock); #1;
      do_reset();

      foreach (vecs[i]) begin
         drive(vecs[i].in);
         #2;
         chk({"tab_ctl_", vecs[i].name}, 32'(ctl_now()), 32'(vecs[i].ctl));
         chk({"tab_fa_", vecs[i].name}, 32'(fwd_a_sel), 32'(vecs[i].fa));
         chk({"tab_fb_", vecs[i].name}, 32'(fwd_b_sel), 32'(vecs[i].fb));
         clk_check(vecs[i].in);
      end

      // Load-use: one stall cycle, then the bubble removes the hazard.
      do_reset();
      step(lu);
      chk("lu_state", 32'(state), 32'd1);
      chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
      v = lu; v.ex_mem_read = 0;
      step(v);
      chk("lu_once", 32'(state), 32'd0);
      chk("lu_once_cnt", 32'(stall_cycles), 32'd1);

      // Memory wait for three cycles.
      do_reset();
      repeat (3) begin
         step(wt);
         chk("mw_state", 32'(state), 32'd3);
      end
      v = wt; v.dmem_ready = 1;
      step(v);
      chk("mw_cnt", 32'(stall_cycles), 32'd3);

      // Wait, branch and load-use together: stall, then flush once.
      do_reset();
      all3 = lu; all3.branch_taken_ex = 1; all3.mem_access = 1; all3.dmem_ready = 0;
      repeat (2) step(all3);
      all3.dmem_ready = 1;
      step(all3);
      chk("sim_state", 32'(state), 32'd2);
      chk("sim_flush", 32'(flush_count), 32'd1);
      chk("sim_stall", 32'(stall_cycles), 32'd2);
      step(idle());
      chk("sim_nolu", 32'(stall_cycles), 32'd2);

      // Saturation of the narrow counter.
      do_reset();
      repeat (20) step(wt);
      chk("sat_hold", 32'(s_stall_cycles), 32'd15);
      chk("sat_wide", 32'(stall_cycles), 32'd20);

      // Reset in the middle of a memory wait.
      do_reset();
      repeat (2) step(wt);
      do_reset();
      step(idle());
      chk("rmw_cnt", 32'(stall_cycles), 32'd0);
      step(wt);
      chk("rmw_restart", 32'(stall_cycles), 32'd1);

      // Randomized traffic with narrow register ranges to provoke matches.
      do_reset();
      repeat (400) begin
         v.id_rs1 = 5'($urandom_range(0, 3));
         v.id_rs2 = 5'($urandom_range(0, 3));
         v.ex_rs1 = 5'($urandom_range(0, 3));
         v.ex_rs2 = 5'($urandom_range(0, 3));
         v.ex_rd  = 5'($urandom_range(0, 3));
         v.mem_rd = 5'($urandom_range(0, 3));
         v.wb_rd  = 5'($urandom_range(0, 3));
         v.id_rs1_used = 1'($urandom);
         v.id_rs2_used = 1'($urandom);
         v.ex_reg_en = 1'($urandom);
         v.ex_mem_read = 1'($urandom);
         v.mem_reg_en = 1'($urandom);
         v.wb_reg_en = 1'($urandom);
         v.mem_access = 1'($urandom);
         v.dmem_ready = ($urandom_range(0, 3) != 0);
         v.branch_taken_ex = ($urandom_range(0, 4) == 0);
         step(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
